// File: rtl/life_pkg.sv
// life_pkg: shared board geometry, FSM states and cell helpers for life_engine
// Cell (r,c) lives at bit 8*r+c of a flattened 64-bit board.
package life_pkg;
  localparam int GRID_N = 8;
  localparam int CELLS = GRID_N * GRID_N;
  localparam logic [2:0] ROW_LAST = 3'(GRID_N - 1);
  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;
  function automatic logic [5:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
    return {r, c};
  endfunction
  function automatic logic [3:0] count8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n += {3'b0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/life_row.sv
// life_row: combinational Conway rule for one 8-cell row
// Ports: up/mid/dn = rows r-1, r, r+1; nxt = next generation of row r.
// LIFE_WRAP_EN defined: columns wrap around; otherwise off-board columns are dead.
module life_row import life_pkg::*; (
  input  logic [GRID_N-1:0] up,
  input  logic [GRID_N-1:0] mid,
  input  logic [GRID_N-1:0] dn,
  output logic [GRID_N-1:0] nxt
);
  logic [GRID_N+1:0] eu, em, ed;
`ifdef LIFE_WRAP_EN
  assign eu = {up[0], up, up[GRID_N-1]};
  assign em = {mid[0], mid, mid[GRID_N-1]};
  assign ed = {dn[0], dn, dn[GRID_N-1]};
`else
  assign eu = {1'b0, up, 1'b0};
  assign em = {1'b0, mid, 1'b0};
  assign ed = {1'b0, dn, 1'b0};
`endif
  for (genvar c = 0; c < GRID_N; c++) begin : g_cell
    logic [3:0] n;
    assign n = count8({eu[c+2:c], ed[c+2:c], em[c+2], em[c]});
    assign nxt[c] = (n == 4'd3) | (mid[c] & (n == 4'd2));
  end
endmodule

// File: rtl/life_engine.sv
// life_engine: 8x8 Game of Life engine, one row per cycle into a shadow board
// Ports: clk, reset (async, active-high), load/seed capture a board, step runs one
// generation; grid = board, busy = generation in flight, done = commit pulse,
// gen_count = generations since load, stable = last commit left the board unchanged.
// LIFE_WRAP_EN defined: toroidal board; otherwise off-board cells are dead.
module life_engine import life_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CELLS-1:0] seed,
  input  logic             step,
  output logic [CELLS-1:0] grid,
  output logic             busy,
  output logic             done,
  output logic [15:0]      gen_count,
  output logic             stable
);
  state_t state, nstate;
  logic [2:0] row, rm, rp;
  logic [CELLS-1:0] shadow;
  logic [15:0] gen_q;
  logic [GRID_N-1:0] up, mid, dn, nxt;
  assign rm = row - 3'd1;
  assign rp = row + 3'd1;
  assign mid = grid[cell_idx(row, 3'd0) +: GRID_N];
`ifdef LIFE_WRAP_EN
  assign up = grid[cell_idx(rm, 3'd0) +: GRID_N];
  assign dn = grid[cell_idx(rp, 3'd0) +: GRID_N];
`else
  assign up = (row == 3'd0) ? '0 : grid[cell_idx(rm, 3'd0) +: GRID_N];
  assign dn = (row == ROW_LAST) ? '0 : grid[cell_idx(rp, 3'd0) +: GRID_N];
`endif
  life_row u_row (.up(up), .mid(mid), .dn(dn), .nxt(nxt));
  assign busy = (state != IDLE);
  assign gen_count = gen_q;
  always_comb begin
    nstate = state;
    nstate = load ? IDLE :
             (state == IDLE) ? (step ? CALC : IDLE) :
             (state == CALC) ? ((row == ROW_LAST) ? COMMIT : CALC) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nstate;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grid <= '0;
      shadow <= '0;
      gen_q <= '0;
      stable <= 1'b0;
      done <= 1'b0;
      row <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        grid <= seed;
        gen_q <= '0;
        stable <= 1'b0;
        row <= '0;
      end else if (state == IDLE) begin
        if (step) row <= '0;
      end else if (state == CALC) begin
        shadow[cell_idx(row, 3'd0) +: GRID_N] <= nxt;
        row <= row + 3'd1;
      end else begin
        grid <= shadow;
        gen_q <= gen_q + 16'd1;
        stable <= (shadow == grid);
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: directed self-checking bench for life_engine
module tb_life_engine;
  logic clk = 1'b0, reset = 1'b1, load = 1'b0, step = 1'b0;
  logic [63:0] seed = '0;
  logic [63:0] grid;
  logic busy, done, stable, seen;
  logic [15:0] gen_count;
  int vectors = 0, miscompares = 0;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;
  localparam logic [63:0] CORNERS = 64'h8100_0000_0000_0081;
  always #5 clk = ~clk;
  life_engine dut (
    .clk(clk), .reset(reset), .load(load), .seed(seed), .step(step),
    .grid(grid), .busy(busy), .done(done), .gen_count(gen_count), .stable(stable)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_load(input logic [63:0] s);
    load = 1'b1;
    seed = s;
    @(negedge clk);
    load = 1'b0;
  endtask
  // step sampled at E0; a stray step pulse mid-CALC must be ignored; returns after E9
  task automatic gen(input logic [63:0] cur);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("busy_E0", busy, 1);
    repeat (3) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
    chk("grid_frozen_E8", grid, cur);
    chk("no_done_E8", done, 0);
    @(negedge clk);
    chk("done_E9", done, 1);
    chk("busy_E9", busy, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_grid", grid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_gen", gen_count, 0);
    chk("rst_stable", stable, 0);
    reset = 1'b0;
    @(negedge clk);
    do_load(BLINK_V);
    chk("blink_load", grid, BLINK_V);
    gen(BLINK_V);
    chk("blink1_grid", grid, BLINK_H);
    chk("blink1_gen", gen_count, 1);
    chk("blink1_stable", stable, 0);
    gen(BLINK_H);
    chk("blink2_grid", grid, BLINK_V);
    chk("blink2_gen", gen_count, 2);
    @(negedge clk);
    chk("blink_done_E10", done, 0);
    chk("blink_not_queued", busy, 0);
    do_load(BLOCK);
    gen(BLOCK);
    chk("block_grid", grid, BLOCK);
    chk("block_stable", stable, 1);
    chk("block_gen", gen_count, 1);
    @(negedge clk);
    do_load(64'h1);
    chk("lone_load_stable", stable, 0);
    gen(64'h1);
    chk("lone1_grid", grid, 0);
    chk("lone1_stable", stable, 0);
    @(negedge clk);
    gen(64'h0);
    chk("lone2_grid", grid, 0);
    chk("lone2_stable", stable, 1);
    chk("lone2_gen", gen_count, 2);
    @(negedge clk);
    do_load(CORNERS);
    gen(CORNERS);
`ifdef LIFE_WRAP_EN
    chk("corner_grid", grid, CORNERS);
    chk("corner_stable", stable, 1);
`else
    chk("corner_grid", grid, 0);
    chk("corner_stable", stable, 0);
`endif
    @(negedge clk);
    do_load(BLINK_V);
    gen(BLINK_V);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
    load = 1'b1;
    seed = BLOCK;
    @(negedge clk);
    load = 1'b0;
    chk("abort_grid", grid, BLOCK);
    chk("abort_gen", gen_count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= done | busy;
    end
    chk("abort_quiet", seen, 0);
    gen(BLOCK);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmid_grid", grid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_gen", gen_count, 0);
    chk("rstmid_stable", stable, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= done | busy | (grid != 64'h0);
    end
    chk("rstmid_quiet", seen, 0);
    do_load(BLOCK);
    force dut.gen_q = 16'hFFFE;
    @(negedge clk);
    release dut.gen_q;
    chk("wrap_preset", gen_count, 16'hFFFE);
    gen(BLOCK);
    chk("wrap_ffff", gen_count, 16'hFFFF);
    gen(BLOCK);
    chk("wrap_zero", gen_count, 16'h0000);
    chk("wrap_grid", grid, BLOCK);
    @(negedge clk);
    load = 1'b1;
    step = 1'b1;
    seed = 64'h1;
    @(negedge clk);
    load = 1'b0;
    step = 1'b0;
    chk("prio_grid", grid, 64'h1);
    chk("prio_busy", busy, 0);
    chk("prio_gen", gen_count, 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= done | busy;
    end
    chk("prio_quiet", seen, 0);
    chk("prio_grid_held", grid, 64'h1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
